voice_allocator: RTL

- Polyphonic note scheduler. Sits between the MIDI byte parser and the per-voice sample-rate generators.
- Accepts parsed MIDI messages and assigns note-on events to one of NUM_VOICES voice slots. Free slots are used first; otherwise the least-recently-allocated slot is stolen.
- Sequences a single shared note-to-period lookup to fill each voice's cycles-between-samples value. Releases voices on note-off.

---
 rtl/midi_pkg.sv | 59 +++++
 rtl/lru_tracker.sv | 52 +++++
 rtl/voice_allocator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the voice allocator: MIDI status codes, the
// all-notes-off controller number, reset defaults for a voice slot, the
// parsed-message struct, the message classifier and the allocator FSM states.
// ---------------------------------------------------------------------------
package midi_pkg;

  // MIDI status high nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;

  // Controller number that silences every voice
  localparam logic [7:0] ALL_NOTES_OFF = 8'd123;

  localparam int NOTE_W = 7;

  // Voice slot defaults: middle C and its period
  localparam logic [NOTE_W-1:0] DEFAULT_NOTE   = 7'd60;
  localparam int                DEFAULT_PERIOD = 747;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_LOOKUP,
    ST_WRITE
  } va_state_e;

  typedef enum logic [1:0] {
    MSG_IGNORE,
    MSG_NOTE_ON,
    MSG_NOTE_OFF,
    MSG_ALL_OFF
  } msg_kind_e;

  typedef struct packed {
    logic [3:0] status;
    logic [7:0] b1;
    logic [7:0] b2;
  } midi_msg_t;

  // Note-on with velocity 0 is a note-off. A data byte with bit 7 set is not
  // a valid data byte, so such messages are dropped on the floor.
  function automatic msg_kind_e classify(input midi_msg_t m);
    msg_kind_e k;
    k = MSG_IGNORE;
    if (!m.b1[7]) begin
      if (m.status == NOTE_ON && m.b2 != 8'd0)
        k = MSG_NOTE_ON;
      else if (m.status == NOTE_OFF || m.status == NOTE_ON)
        k = MSG_NOTE_OFF;
      else if (m.status == CTRL && m.b1 == ALL_NOTES_OFF)
        k = MSG_ALL_OFF;
    end
    return k;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// ---------------------------------------------------------------------------
// lru_tracker
// Keeps an age per voice slot (0 = most recently allocated). The ages are
// always a permutation of 0..NUM_VOICES-1, so exactly one slot carries the
// maximum age and that slot is the steal candidate.
//
// Ports
//   clk_in      clock
//   rst_in      async active-low reset; slot v starts with age v
//   touch_i     mark touch_idx_i as just allocated (one-cycle strobe)
//   touch_idx_i slot being allocated
//   oldest_o    slot holding age NUM_VOICES-1
// ---------------------------------------------------------------------------
module lru_tracker #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] oldest_o
);

  logic [NUM_VOICES-1:0][IDX_W-1:0] age_q;
  logic [IDX_W-1:0]                 touch_age;

  assign touch_age = age_q[touch_idx_i];

  // Slots younger than the touched one move back by one; the touched slot
  // becomes youngest. Older slots keep their age, so the set stays a
  // permutation.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= IDX_W'(v);
    end else if (touch_i) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (IDX_W'(v) == touch_idx_i)
          age_q[v] <= '0;
        else if (age_q[v] < touch_age)
          age_q[v] <= age_q[v] + IDX_W'(1);
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (age_q[v] == IDX_W'(NUM_VOICES - 1)) oldest_o = IDX_W'(v);
  end

endmodule

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
// Polyphonic note scheduler between the MIDI parser and the per-voice
// generators. Note-ons pick a slot (retrigger > lowest free > oldest), fetch
// the period from a shared external lookup, then write the slot. Note-offs
// and all-notes-off act on the gates directly from IDLE.
//
// Ports
//   clk_in, rst_in         clock, async active-low reset
//   status/data_byte1/2    parsed MIDI message, qualified by valid_in
//   msg_ready_out          high only in IDLE; valid_in while low is dropped
//   lut_req_out/note_out   lookup request, note held until lut_valid_in
//   lut_period_in/valid_in lookup answer, only honoured in LOOKUP
//   voice_gate_out         per-voice gate
//   voice_note_out         per-voice note, voice v at [7v+6:7v]
//   voice_period_out       per-voice period, voice v at [PW*v +: PW]
//   voice_update_out       one-cycle pulse with each new period
//   drop_count_out         saturating count of dropped messages
// ---------------------------------------------------------------------------
module voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 24
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [3:0]                       status,
  input  logic [7:0]                       data_byte1,
  input  logic [7:0]                       data_byte2,
  input  logic                             valid_in,
  output logic                             msg_ready_out,
  output logic                             lut_req_out,
  output logic [NOTE_W-1:0]                lut_note_out,
  input  logic [PERIOD_W-1:0]              lut_period_in,
  input  logic                             lut_valid_in,
  output logic [NUM_VOICES-1:0]            voice_gate_out,
  output logic [NOTE_W*NUM_VOICES-1:0]     voice_note_out,
  output logic [PERIOD_W*NUM_VOICES-1:0]   voice_period_out,
  output logic [NUM_VOICES-1:0]            voice_update_out,
  output logic [7:0]                       drop_count_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  va_state_e                              state_q;
  logic [NOTE_W-1:0]                      note_q;
  logic [IDX_W-1:0]                       tgt_q, tgt_d;
  logic [PERIOD_W-1:0]                    period_q;
  logic                                   lut_req_q;
  logic [NUM_VOICES-1:0]                  gate_q, update_q;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]      vnote_q;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0]    vperiod_q;
  logic [7:0]                             drop_q;

  midi_msg_t             msg;
  msg_kind_e             kind;
  logic                  accept;
  logic [NUM_VOICES-1:0] off_mask;
  logic [IDX_W-1:0]      oldest;

  assign msg           = {status, data_byte1, data_byte2};
  assign kind          = classify(msg);
  assign msg_ready_out = (state_q == ST_IDLE);
  assign accept        = valid_in && msg_ready_out;

  // Voices sounding the note named in the incoming message
  always_comb begin
    off_mask = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      off_mask[v] = gate_q[v] && (vnote_q[v] == data_byte1[NOTE_W-1:0]);
  end

  // Slot choice for the latched note. Descending scan so the lowest index
  // wins among free slots; at most one gated slot can hold the same note.
  always_comb begin
    logic             hit, free;
    logic [IDX_W-1:0] hit_idx, free_idx;
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate_q[v] && vnote_q[v] == note_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(v);
      end
      if (!gate_q[v]) begin
        free     = 1'b1;
        free_idx = IDX_W'(v);
      end
    end
    if (hit)       tgt_d = hit_idx;
    else if (free) tgt_d = free_idx;
    else           tgt_d = oldest;
  end

  lru_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W)
  ) u_lru (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .touch_i     (state_q == ST_WRITE),
    .touch_idx_i (tgt_q),
    .oldest_o    (oldest)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      note_q    <= DEFAULT_NOTE;
      tgt_q     <= '0;
      period_q  <= PERIOD_W'(DEFAULT_PERIOD);
      lut_req_q <= 1'b0;
      gate_q    <= '0;
      update_q  <= '0;
      drop_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vnote_q[v]   <= DEFAULT_NOTE;
        vperiod_q[v] <= PERIOD_W'(DEFAULT_PERIOD);
      end
    end else begin
      update_q <= '0;
      if (valid_in && !msg_ready_out && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (kind)
              MSG_NOTE_ON: begin
                note_q  <= data_byte1[NOTE_W-1:0];
                state_q <= ST_ALLOC;
              end
              MSG_NOTE_OFF: gate_q <= gate_q & ~off_mask;
              MSG_ALL_OFF:  gate_q <= '0;
              default: ;
            endcase
          end
        end
        ST_ALLOC: begin
          tgt_q     <= tgt_d;
          lut_req_q <= 1'b1;
          state_q   <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          if (lut_valid_in) begin
            period_q  <= lut_period_in;
            lut_req_q <= 1'b0;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A steal or retrigger leaves the gate high; only note/period move
          gate_q[tgt_q]    <= 1'b1;
          vnote_q[tgt_q]   <= note_q;
          vperiod_q[tgt_q] <= period_q;
          update_q[tgt_q]  <= 1'b1;
          state_q          <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lut_req_out      = lut_req_q;
  assign lut_note_out     = note_q;
  assign voice_gate_out   = gate_q;
  assign voice_note_out   = vnote_q;
  assign voice_period_out = vperiod_q;
  assign voice_update_out = update_q;
  assign drop_count_out   = drop_q;

endmodule
